// File: rtl/router_input_fifo.sv
// Per-port NoC router flit buffer: first-word-fall-through head with flit_id/dst_addr decode for LBDR.
// Latency: a flit written at edge N is visible on data_out right after N; credit_out pulses the cycle after a dequeue.
// Backpressure: a write while full is taken only alongside a read; otherwise it is dropped and overflow sticks.
module router_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] rx,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  credit_out,
    output logic                  overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [AW:0]           count;
    logic                  do_rd;
    logic                  do_wr;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // A read on an empty FIFO is ignored even if a write lands in the same cycle.
    assign do_rd = read_en & ~empty;
    assign do_wr = valid_in & (~full | read_en);

    always_ff @(posedge clk) begin
        if (do_wr && !rst) begin
            mem[wr_ptr] <= rx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            credit_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            credit_out <= do_rd;
            overflow   <= overflow | (valid_in & full & ~read_en);
        end
    end

    assign data_out = mem[rd_ptr];
    assign flit_id  = data_out[DATA_WIDTH-1 -: 3];
    assign dst_addr = data_out[3:0];

endmodule

// File: tb/tb_router_input_fifo.sv
// Bench for router_input_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_router_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] rx;
    logic          read_en;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic [2:0]    flit_id;
    logic [3:0]    dst_addr;
    logic          credit_out;
    logic          overflow;

    router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .rx         (rx),
        .read_en    (read_en),
        .data_out   (data_out),
        .empty      (empty),
        .full       (full),
        .flit_id    (flit_id),
        .dst_addr   (dst_addr),
        .credit_out (credit_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cred_cnt = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: the FIFO as a plain queue.
    logic [DW-1:0] q[$];
    bit            m_ovf    = 0;
    bit            m_credit = 0;
    bit            chk_en   = 0;

    always @(posedge clk) begin
        bit rd, wr;
        if (rst) begin
            q.delete();
            m_ovf    = 0;
            m_credit = 0;
            chk_en   = 1;
        end else begin
            rd = read_en && (q.size() > 0);
            wr = valid_in && ((q.size() < DEPTH) || read_en);
            if (valid_in && q.size() == DEPTH && !read_en) m_ovf = 1;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(rx);
            m_credit = rd;
        end
    end

    always @(negedge clk) begin
        logic [DW-1:0] head;
        logic [2:0]    fid;
        logic [3:0]    dst;
        if (chk_en) begin
            check("empty",    empty,      q.size() == 0);
            check("full",     full,       q.size() == DEPTH);
            check("overflow", overflow,   m_ovf);
            check("credit",   credit_out, m_credit);
            if (q.size() > 0) begin
                head = q[0];
                fid  = head[DW-1 -: 3];
                dst  = head[3:0];
                check("data_out", data_out, head);
                check("flit_id",  flit_id,  fid);
                check("dst_addr", dst_addr, dst);
            end
            if (credit_out === 1'b1) cred_cnt++;
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        valid_in = v;
        rx       = d;
        read_en  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, '0, 0);
        rst = 1'b0;
    endtask

    logic [DW-1:0] exp3 [4];
    int            c0;

    initial begin
        exp3[0] = 32'h2000_0001;
        exp3[1] = 32'h4000_0000;
        exp3[2] = 32'h4000_0000;
        exp3[3] = 32'h8000_0000;

        // Reset held two cycles with a write pending
        rst = 1'b1;
        step(1, 32'hFFFF_FFFF, 0);
        step(1, 32'hFFFF_FFFF, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_credit", credit_out, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        step(0, '0, 0);
        check("rst_nothing_stored", empty, 1);

        // Single header flit
        step(1, 32'h2000_0007, 0);
        check("single_empty", empty, 0);
        check("single_fid", flit_id, 3'b001);
        check("single_dst", dst_addr, 4'h7);
        step(0, '0, 1);
        check("single_drained", empty, 1);
        check("single_credit", credit_out, 1);
        step(0, '0, 0);
        check("single_credit_end", credit_out, 0);

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) step(1, exp3[i], 0);
        check("fill_full", full, 1);
        step(1, 32'hDEAD_BEEF, 0);
        check("ovf_set", overflow, 1);
        check("ovf_head", data_out, 32'h2000_0001);
        c0 = cred_cnt;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", data_out, exp3[i]);
            step(0, '0, 1);
        end
        step(0, '0, 0);
        check("drain_empty", empty, 1);
        check("drain_credits", cred_cnt - c0, 4);
        check("ovf_sticky", overflow, 1);

        // Full with simultaneous read and write
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 32'(i), 0);
        step(1, 32'hA, 1);
        check("rw_full", full, 1);
        check("rw_credit", credit_out, 1);
        check("rw_ovf", overflow, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1);
        check("rw_fourth", data_out, 32'hA);
        step(0, '0, 1);
        check("rw_empty", empty, 1);

        // Empty with simultaneous read and write
        step(0, '0, 0);
        step(1, 32'h2000_0005, 1);
        check("er_empty", empty, 0);
        check("er_dst", dst_addr, 4'h5);
        check("er_credit", credit_out, 0);
        check("er_head", data_out, 32'h2000_0005);
        step(0, '0, 1);

        // Streaming through the pointer wrap
        step(1, 32'h100, 0);
        for (int i = 1; i <= 10; i++) step(1, 32'h100 + 32'(i), 1);
        check("stream_head", data_out, 32'h10A);
        step(0, '0, 1);
        check("stream_empty", empty, 1);

        // Mid-operation reset with three flits stored and overflow set
        for (int i = 0; i < 5; i++) step(1, 32'h4000_0000 + 32'(i), 0);
        step(0, '0, 1);
        check("pre_rst_ovf", overflow, 1);
        check("pre_rst_head", data_out, 32'h4000_0001);
        rst = 1'b1;
        step(1, 32'h2000_0009, 1);
        rst = 1'b0;
        check("mid_rst_empty", empty, 1);
        check("mid_rst_ovf", overflow, 0);
        step(0, '0, 0);
        check("mid_rst_credit", credit_out, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            step(logic'($urandom_range(0, 99) < 60), $urandom, logic'($urandom_range(0, 99) < 45));
        end
        rst = 1'b0;
        step(0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
